// File: rtl/adsr_env.sv
// rtl/adsr_env.sv - ADSR envelope generator: gate in, unsigned VCA control level out.
// Optional feature: ADSR_RETRIG_EN adds the retrig hard-restart input.
module adsr_env #(
  parameter int WIDTH = 8,
  parameter int FRAC  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick,
  input  logic             gate,
  input  logic [WIDTH-1:0] attack,
  input  logic [WIDTH-1:0] decay,
  input  logic [WIDTH-1:0] sustain,
  input  logic [WIDTH-1:0] release_rate,
`ifdef ADSR_RETRIG_EN
  input  logic             retrig,
`endif
  output logic [WIDTH-1:0] cv_out,
  output logic [2:0]       stage,
  output logic             busy
);

  localparam int ACC_W = WIDTH + FRAC;
  localparam logic [ACC_W-1:0] ACC_MAX = {ACC_W{1'b1}};
  localparam logic [ACC_W:0]   ONE     = {{ACC_W{1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ATTACK  = 3'd1,
    ST_DECAY   = 3'd2,
    ST_SUSTAIN = 3'd3,
    ST_RELEASE = 3'd4
  } state_t;

  state_t           state, state_nxt;
  logic [ACC_W-1:0] acc, acc_nxt;
  logic             gate_q;
  logic             rise, fall;
  logic [ACC_W-1:0] tgt;
  logic [ACC_W:0]   att_sum, dec_diff, rel_diff;

  assign rise = gate & ~gate_q;
  assign fall = ~gate & gate_q;
  assign tgt  = {sustain, {FRAC{1'b0}}};

  // Steps are one bit wider than acc so overflow/underflow show up in the MSB.
  assign att_sum  = {1'b0, acc} + {{(FRAC+1){1'b0}}, attack} + ONE;
  assign dec_diff = {1'b0, acc} - ({{(FRAC+1){1'b0}}, decay} + ONE);
  assign rel_diff = {1'b0, acc} - ({{(FRAC+1){1'b0}}, release_rate} + ONE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc    <= '0;
      state  <= ST_IDLE;
      // Loading the live gate keeps a gate held through reset from looking like a fresh rise.
      gate_q <= gate;
    end else begin
      acc    <= acc_nxt;
      state  <= state_nxt;
      gate_q <= gate;
    end
  end

  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
`ifdef ADSR_RETRIG_EN
    if (retrig && gate_q) begin
      acc_nxt   = '0;
      state_nxt = ST_ATTACK;
    end else
`endif
    if (rise) begin
      state_nxt = ST_ATTACK;
    end else if (fall && (state == ST_ATTACK || state == ST_DECAY || state == ST_SUSTAIN)) begin
      state_nxt = ST_RELEASE;
    end else if (tick) begin
      case (state)
        ST_ATTACK: begin
          if (att_sum >= {1'b0, ACC_MAX}) begin
            acc_nxt   = ACC_MAX;
            state_nxt = ST_DECAY;
          end else begin
            acc_nxt = att_sum[ACC_W-1:0];
          end
        end
        ST_DECAY: begin
          if (acc <= tgt || dec_diff[ACC_W] || dec_diff[ACC_W-1:0] <= tgt) begin
            acc_nxt   = tgt;
            state_nxt = ST_SUSTAIN;
          end else begin
            acc_nxt = dec_diff[ACC_W-1:0];
          end
        end
        ST_SUSTAIN: acc_nxt = tgt;
        ST_RELEASE: begin
          if (rel_diff[ACC_W] || rel_diff[ACC_W-1:0] == '0) begin
            acc_nxt   = '0;
            state_nxt = ST_IDLE;
          end else begin
            acc_nxt = rel_diff[ACC_W-1:0];
          end
        end
        default: acc_nxt = '0;
      endcase
    end
  end

  assign cv_out = acc[ACC_W-1:FRAC];
  assign stage  = state;
  assign busy   = (state != ST_IDLE);

endmodule

// File: tb/tb_adsr_env.sv
// tb/tb_adsr_env.sv - directed self-checking bench for adsr_env (WIDTH=8, FRAC=8, tick every 4 clk).
module tb_adsr_env;

  logic       clk = 1'b0;
  logic       rst_n, tick, gate;
  logic [7:0] attack, decay, sustain, release_rate;
  logic [7:0] cv_out;
  logic [2:0] stage;
  logic       busy;
`ifdef ADSR_RETRIG_EN
  logic       retrig;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  adsr_env #(.WIDTH(8), .FRAC(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .tick         (tick),
    .gate         (gate),
    .attack       (attack),
    .decay        (decay),
    .sustain      (sustain),
    .release_rate (release_rate),
`ifdef ADSR_RETRIG_EN
    .retrig       (retrig),
`endif
    .cv_out       (cv_out),
    .stage        (stage),
    .busy         (busy)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick = 1'b1;
      clks(1);
      tick = 1'b0;
      clks(3);
    end
  endtask

  initial begin
    rst_n = 1'b0; tick = 1'b0; gate = 1'b0;
    attack = 8'd255; decay = 8'd255; sustain = 8'h80; release_rate = 8'd63;
`ifdef ADSR_RETRIG_EN
    retrig = 1'b0;
`endif
    clks(2);
    check("rst_cv", cv_out, 0);
    check("rst_stage", stage, 0);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;
    clks(2);

    // attack from idle
    gate = 1'b1;
    clks(2);
    check("att_stage", stage, 1);
    check("att_busy", busy, 1);
    check("att_cv0", cv_out, 0);
    ticks(255);
    check("att_cv255", cv_out, 8'hFF);
    check("att_stage255", stage, 1);
    ticks(1);
    check("att_cv256", cv_out, 8'hFF);
    check("att_to_decay", stage, 2);

    // decay to sustain, then live sustain change
    ticks(127);
    check("dec_cv127", cv_out, 8'h80);
    check("dec_stage127", stage, 2);
    ticks(1);
    check("sus_stage", stage, 3);
    check("sus_cv", cv_out, 8'h80);
    sustain = 8'h40;
    clks(2);
    check("sus_hold", cv_out, 8'h80);
    ticks(1);
    check("sus_track", cv_out, 8'h40);

    // release from 0x40 at -64 per tick
    gate = 1'b0;
    clks(2);
    check("rel_stage", stage, 4);
    check("rel_cv0", cv_out, 8'h40);
    ticks(255);
    check("rel_cv255", cv_out, 0);
    check("rel_busy255", busy, 1);
    ticks(1);
    check("rel_idle", stage, 0);
    check("rel_busy", busy, 0);

    // legato: release at 0x30, rise coincident with tick
    gate = 1'b1;
    clks(2);
    ticks(48);
    check("leg_att_cv", cv_out, 8'h30);
    gate = 1'b0;
    clks(2);
    check("leg_rel", stage, 4);
    gate = 1'b1;
    tick = 1'b1;
    clks(1);
    tick = 1'b0;
    clks(1);
    check("leg_stage", stage, 1);
    check("leg_nostep", cv_out, 8'h30);
    ticks(1);
    check("leg_step", cv_out, 8'h31);

    // reset mid-attack with gate held high
    ticks(63);
    check("rstm_cv_pre", cv_out, 8'h70);
    rst_n = 1'b0;
    clks(1);
    rst_n = 1'b1;
    check("rstm_cv", cv_out, 0);
    check("rstm_stage", stage, 0);
    check("rstm_busy", busy, 0);
    ticks(4);
    check("rstm_hold_stage", stage, 0);
    check("rstm_hold_cv", cv_out, 0);
    gate = 1'b0;
    clks(2);
    gate = 1'b1;
    clks(2);
    check("rstm_fresh_rise", stage, 1);

    // back to sustain at 0x80
    sustain = 8'h80;
    ticks(256);
    check("r6_decay", stage, 2);
    ticks(128);
    check("r6_sus_stage", stage, 3);
    check("r6_sus_cv", cv_out, 8'h80);
`ifdef ADSR_RETRIG_EN
    retrig = 1'b1;
    clks(1);
    retrig = 1'b0;
    check("retrig_stage", stage, 1);
    check("retrig_cv", cv_out, 0);
`else
    gate = 1'b0;
    clks(1);
    check("r6_rel", stage, 4);
    gate = 1'b1;
    clks(2);
    check("r6_leg_stage", stage, 1);
    check("r6_leg_cv", cv_out, 8'h80);
    ticks(1);
    check("r6_leg_step", cv_out, 8'h81);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
